// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// drives per-state datapath controls, flags illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_ADDI  = 1'b1,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       fetchWr;
        logic       pcWrite;
        logic       branchEq;
        logic       branchNe;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
    } ctrl_t;

    // Controls are registered from the next state, so they are a pure function of the current state.
    function automatic ctrl_t decodeCtrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.fetchWr = 1'b1; c.memRead = 1'b1; c.aluSrcB = 2'b01; end
            DECODE: c.aluSrcB = 2'b11;
            MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMRD:  begin c.memRead = 1'b1; c.iord = 1'b1; end
            MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
            MEMWR:  begin c.memWrite = 1'b1; c.iord = 1'b1; end
            EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            ALUWB:  begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            BRANCH: begin
                c.aluSrcA  = 1'b1;
                c.aluOp    = 2'b01;
                c.pcSrc    = 2'b01;
                c.branchEq = (op == OP_BEQ);
                c.branchNe = (op == OP_BNE);
            end
            ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            ADDIWB: c.regWrite = 1'b1;
            JUMP:   begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] count_q;
    logic             memRdy;
    logic             illegalDecode;
    logic             retire;

    assign memRdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d       = state_q;
        illegalDecode = 1'b0;
        case (state_q)
            FETCH:  if (memRdy) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_BNE: begin
                        state_d       = SUPPORT_BNE ? BRANCH : FETCH;
                        illegalDecode = !SUPPORT_BNE;
                    end
                    OP_ADDI: begin
                        state_d       = SUPPORT_ADDI ? ADDIEX : FETCH;
                        illegalDecode = !SUPPORT_ADDI;
                    end
                    default: begin
                        state_d       = FETCH;
                        illegalDecode = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (memRdy) state_d = MEMWB;
            MEMWR:  if (memRdy) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Only completed instructions retire; the illegal path also returns to FETCH but from DECODE.
    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= decodeCtrl(FETCH, 6'b000000);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decodeCtrl(state_d, opcode);
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    // Outputs are gated by rst_n so every control is low for the whole time reset is held.
    assign pc_write    = rst_n & (ctrl_q.pcWrite | (ctrl_q.fetchWr & memRdy));
    assign ir_write    = rst_n & ctrl_q.fetchWr & memRdy;
    assign branch_eq   = rst_n & ctrl_q.branchEq;
    assign branch_ne   = rst_n & ctrl_q.branchNe;
    assign iord        = rst_n & ctrl_q.iord;
    assign mem_read    = rst_n & ctrl_q.memRead;
    assign mem_write   = rst_n & ctrl_q.memWrite;
    assign mem_to_reg  = rst_n & ctrl_q.memToReg;
    assign reg_dst     = rst_n & ctrl_q.regDst;
    assign reg_write   = rst_n & ctrl_q.regWrite;
    assign alu_src_a   = rst_n & ctrl_q.aluSrcA;
    assign alu_src_b   = rst_n ? ctrl_q.aluSrcB : 2'b00;
    assign alu_op      = rst_n ? ctrl_q.aluOp : 2'b00;
    assign pc_src      = rst_n ? ctrl_q.pcSrc : 2'b00;
    assign illegal     = rst_n & illegalDecode;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default build plus an addi-less build and a 4-bit counter build
// driven by the same stimulus.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic        pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        naPw, naBe, naBn, naIord, naMr, naMw, naIrw, naM2r, naRd, naRw, naAsa, naIllegal;
    logic [1:0]  naAsb, naAop, naPcs;
    logic [3:0]  naState;
    logic [31:0] naCount;

    logic        c4Pw, c4Be, c4Bn, c4Iord, c4Mr, c4Mw, c4Irw, c4M2r, c4Rd, c4Rw, c4Asa, c4Illegal;
    logic [1:0]  c4Asb, c4Aop, c4Pcs;
    logic [3:0]  c4State;
    logic [3:0]  c4Count;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    multicycle_control #(.SUPPORT_ADDI(1'b0)) dutNoAddi (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(naPw), .branch_eq(naBe), .branch_ne(naBn), .iord(naIord),
        .mem_read(naMr), .mem_write(naMw), .ir_write(naIrw), .mem_to_reg(naM2r),
        .reg_dst(naRd), .reg_write(naRw), .alu_src_a(naAsa), .alu_src_b(naAsb),
        .alu_op(naAop), .pc_src(naPcs), .illegal(naIllegal), .state(naState), .instr_count(naCount)
    );

    multicycle_control #(.CNT_W(4)) dutCnt4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(c4Pw), .branch_eq(c4Be), .branch_ne(c4Bn), .iord(c4Iord),
        .mem_read(c4Mr), .mem_write(c4Mw), .ir_write(c4Irw), .mem_to_reg(c4M2r),
        .reg_dst(c4Rd), .reg_write(c4Rw), .alu_src_a(c4Asa), .alu_src_b(c4Asb),
        .alu_op(c4Aop), .pc_src(c4Pcs), .illegal(c4Illegal), .state(c4State), .instr_count(c4Count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #2;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_ir_write", 32'(ir_write), 32'd0);
        checkOutput("rst_count", instr_count, 32'd0);
        resetAll();

        // lw up to MEMRD, then reset mid-instruction
        applyStimulus(6'b100011, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(6'b100011, 1'b0);
        checkOutput("pre_abort_state", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_state", 32'(state), 32'd0);
        checkOutput("abort_mem_read", 32'(mem_read), 32'd0);
        checkOutput("abort_iord", 32'(iord), 32'd0);
        checkOutput("abort_alu_src_b", 32'(alu_src_b), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(6'b000000, 1'b1);
        checkOutput("release_mem_read", 32'(mem_read), 32'd1);
        checkOutput("release_alu_src_b", 32'(alu_src_b), 32'd1);
        checkOutput("release_count", instr_count, 32'd0);

        // R-type, zero wait states
        nextCycle();
        checkOutput("r_decode", 32'(state), 32'd1);
        checkOutput("r_decode_srcb", 32'(alu_src_b), 32'd3);
        nextCycle();
        checkOutput("r_exec", 32'(state), 32'd6);
        checkOutput("r_exec_aluop", 32'(alu_op), 32'd2);
        nextCycle();
        checkOutput("r_aluwb", 32'(state), 32'd7);
        checkOutput("r_reg_write", 32'(reg_write), 32'd1);
        checkOutput("r_reg_dst", 32'(reg_dst), 32'd1);
        nextCycle();
        checkOutput("r_fetch", 32'(state), 32'd0);
        checkOutput("r_count", instr_count, 32'd1);

        // lw with 2 fetch waits and 3 memory waits
        applyStimulus(6'b100011, 1'b0);
        checkOutput("lw_f1_irw", 32'(ir_write), 32'd0);
        checkOutput("lw_f1_mrd", 32'(mem_read), 32'd1);
        nextCycle();
        checkOutput("lw_f2_irw", 32'(ir_write), 32'd0);
        checkOutput("lw_f2_state", 32'(state), 32'd0);
        nextCycle();
        applyStimulus(6'b100011, 1'b1);
        checkOutput("lw_f3_irw", 32'(ir_write), 32'd1);
        checkOutput("lw_f3_pcw", 32'(pc_write), 32'd1);
        nextCycle();
        checkOutput("lw_decode_irw", 32'(ir_write), 32'd0);
        nextCycle();
        checkOutput("lw_memadr", 32'(state), 32'd2);
        checkOutput("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
        nextCycle();
        applyStimulus(6'b100011, 1'b0);
        checkOutput("lw_memrd", 32'(state), 32'd3);
        checkOutput("lw_memrd_iord", 32'(iord), 32'd1);
        nextCycle();
        nextCycle();
        checkOutput("lw_memrd_hold", 32'(state), 32'd3);
        nextCycle();
        applyStimulus(6'b100011, 1'b1);
        checkOutput("lw_memrd_last", 32'(state), 32'd3);
        nextCycle();
        checkOutput("lw_memwb", 32'(state), 32'd4);
        checkOutput("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        checkOutput("lw_reg_write", 32'(reg_write), 32'd1);
        nextCycle();
        checkOutput("lw_count", instr_count, 32'd2);

        // sw, beq, bne
        applyStimulus(6'b101011, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("sw_state", 32'(state), 32'd5);
        checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
        checkOutput("sw_iord", 32'(iord), 32'd1);
        nextCycle();
        applyStimulus(6'b000100, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq_state", 32'(state), 32'd8);
        checkOutput("beq_branch_eq", 32'(branch_eq), 32'd1);
        checkOutput("beq_branch_ne", 32'(branch_ne), 32'd0);
        checkOutput("beq_pc_src", 32'(pc_src), 32'd1);
        nextCycle();
        applyStimulus(6'b000101, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("bne_branch_eq", 32'(branch_eq), 32'd0);
        checkOutput("bne_branch_ne", 32'(branch_ne), 32'd1);
        nextCycle();
        checkOutput("sbb_count", instr_count, 32'd5);

        // illegal opcode, then addi on both builds
        applyStimulus(6'b111111, 1'b1);
        nextCycle();
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        nextCycle();
        checkOutput("ill_clear", 32'(illegal), 32'd0);
        checkOutput("ill_state", 32'(state), 32'd0);
        checkOutput("ill_count", instr_count, 32'd5);
        applyStimulus(6'b001000, 1'b1);
        nextCycle();
        checkOutput("addi_legal", 32'(illegal), 32'd0);
        checkOutput("addi_na_illegal", 32'(naIllegal), 32'd1);
        nextCycle();
        checkOutput("addi_ex", 32'(state), 32'd9);
        checkOutput("addi_na_state", 32'(naState), 32'd0);
        checkOutput("addi_na_count", naCount, 32'd5);
        nextCycle();
        checkOutput("addi_wb", 32'(state), 32'd10);
        checkOutput("addi_wb_rdst", 32'(reg_dst), 32'd0);
        nextCycle();
        checkOutput("addi_count", instr_count, 32'd6);

        // 17 jumps: 4-bit counter wraps to 1
        resetAll();
        applyStimulus(6'b000010, 1'b1);
        for (int i = 0; i < 17; i++) begin
            nextCycle();
            nextCycle();
            checkOutput("j_pc_src", 32'(pc_src), 32'd2);
            nextCycle();
        end
        checkOutput("j_count32", instr_count, 32'd17);
        checkOutput("j_count4", 32'(c4Count), 32'd1);
        checkOutput("j_c4_state", 32'(c4State), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath. Successor to the single-cycle combinational opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-state datapath controls.
- Supports a variable-latency memory handshake, optional opcodes, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the shared-memory datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- SUPPORT_ADDI, 1, 1 = addi (001000) legal; 0 = addi decodes as illegal.
- SUPPORT_BNE, 1, 1 = bne (000101) legal; 0 = bne decodes as illegal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  Clock, rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from the cycle after ir_write until the next fetch.
- mem_ready  in  1  Memory completes the current access this cycle.
- pc_write  out  1  Unconditional PC load.
- branch_eq  out  1  PC load if ALU zero.
- branch_ne  out  1  PC load if not ALU zero.
- iord  out  1  Memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  Memory read request.
- mem_write  out  1  Memory write request.
- ir_write  out  1  Instruction register load.
- mem_to_reg  out  1  Writeback data source: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  Destination register: 1 = rd, 0 = rt.
- reg_write  out  1  Register file write.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  out  1  One-cycle pulse on an undecodable opcode.
- state  out  4  Current state encoding (debug).
- instr_count  out  CNT_W  Retired instructions.

Behaviour:
- Reset: async on rst_n=0. State goes to FETCH (0) and instr_count to 0. While rst_n=0, every control output and illegal is forced to 0.
- Controls are a Moore function of state, except pc_write and ir_write in FETCH, which are qualified by mem_ready. All unlisted outputs are 0.
- State encodings and controls:
  - FETCH=0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR=2: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD=3: mem_read=1, iord=1.
  - MEMWB=4: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR=5: mem_write=1, iord=1.
  - EXEC=6: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB=7: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. branch_eq=(opcode==000100); branch_ne=(opcode==000101).
  - ADDIEX=9: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB=10: reg_write=1, reg_dst=0, mem_to_reg=0.
  - JUMP=11: pc_write=1, pc_src=10.
  - Encodings 12 to 15 are unreachable; if entered, return to FETCH next cycle with all outputs 0.
- Transitions:
  - FETCH to DECODE only when mem_ready=1 (or MEM_HANDSHAKE=0); otherwise hold with mem_read held high.
  - DECODE: 000000 to EXEC; 100011 or 101011 to MEMADR; 000100 to BRANCH; 000101 to BRANCH if SUPPORT_BNE; 001000 to ADDIEX if SUPPORT_ADDI; 000010 to JUMP.
  - DECODE, any other opcode: illegal=1 for that cycle, next state FETCH, no retire.
  - MEMADR: lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: hold until mem_ready, then go to MEMWB.
  - MEMWR: hold until mem_ready, then go to FETCH.
  - EXEC to ALUWB. ADDIEX to ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: go to FETCH.
- Cycle counts with zero wait states: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3. Each wait cycle adds 1.
- instr_count increments by 1 on every transition into FETCH from a terminal state: MEMWB, MEMWR (on mem_ready), ALUWB, ADDIWB, BRANCH, JUMP. It wraps modulo 2^CNT_W. The illegal path does not count.
- Reset asserted mid-instruction aborts immediately. No retire is counted and the FSM restarts at FETCH after rst_n deasserts.
- opcode is sampled only in DECODE, MEMADR and BRANCH. Changes in other states have no effect.

Test Plan:
- Reset with rst_n=0 in MEMRD: all outputs 0 and state=0 immediately. After release: mem_read=1, alu_src_b=01, instr_count=0.
- R-type with mem_ready tied 1: states 0,1,6,7,0. reg_write=1 with reg_dst=1 in cycle 4. instr_count goes 0 to 1.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD: ir_write pulses once, exactly on the mem_ready cycle. Total 10 cycles, ending with mem_to_reg=1 and reg_write=1.
- sw then beq then bne: MEMWR asserts mem_write=1, iord=1. BRANCH asserts branch_eq=1 for beq and branch_ne=1 for bne. instr_count advances by 3.
- opcode 111111 in DECODE: illegal=1 for one cycle, next state 0, instr_count unchanged. With SUPPORT_ADDI=0, opcode 001000 also produces illegal=1.
- CNT_W=4: retire 17 j instructions (3 cycles each, pc_src=10 in JUMP); instr_count reads 1 after the wrap.
